rtc_bus_reader: RTL and testbench
=================================

RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 SHALL have parameter T_PH, default 4, meaning the number of clk cycles in each bus phase; legal range is 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: read request, sampled only in IDLE.
REQ-005 SHALL have port addr, input, 8 bits: RTC register address, captured when start is accepted.
REQ-006 SHALL have port data_in, input, 8 bits: value read from the shared RTC address/data bus.
REQ-007 SHALL have port AD_l, output, 1 bit: address strobe to the RTC, active-low.
REQ-008 SHALL have port CS_l, output, 1 bit: chip select to the RTC, active-low.
REQ-009 SHALL have port RD_l, output, 1 bit: read strobe to the RTC, active-low.
REQ-010 SHALL have port RW_l, output, 1 bit: write strobe to the RTC, active-low.
REQ-011 SHALL have port bus_out, output, 8 bits: value driven onto the shared bus.
REQ-012 SHALL have port bus_oe, output, 1 bit: bus output enable; when 1, bus_out drives the bus.
REQ-013 SHALL have port data_out, output, 8 bits: last register value read.
REQ-014 SHALL have port busy, output, 1 bit: high while a read cycle is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse marking read completion.

Function
REQ-016 SHALL implement a five-state FSM: IDLE, ADDR, GAP1, READ, GAP2.
REQ-017 In IDLE with start=1, SHALL latch addr into an internal register, clear the phase counter, and move to ADDR at the same edge.
REQ-018 SHALL keep each of ADDR, GAP1, READ and GAP2 for exactly T_PH cycles, timed by a phase counter that counts 0..T_PH-1 and clears on every state change.
REQ-019 In ADDR, SHALL drive AD_l=0, CS_l=0, RW_l=0, RD_l=1, bus_oe=1 and bus_out=latched addr.
REQ-020 In GAP1, SHALL drive AD_l=1, CS_l=1, RW_l=1, RD_l=1, keep bus_oe=1, and hold bus_out=latched addr (address hold time).
REQ-021 In READ, SHALL drive AD_l=1, CS_l=0, RD_l=0, RW_l=1 and bus_oe=0.
REQ-022 SHALL register data_in into data_out only on the last READ cycle (counter = T_PH-1); data_out SHALL hold its value at all other times.
REQ-023 In GAP2 and IDLE, SHALL drive AD_l, CS_l, RD_l and RW_l to 1 and bus_oe to 0.
REQ-024 SHALL decode all bus controls from registered state so that they are glitch-free; at no time SHALL RD_l=0 and RW_l=0 together, and at no time SHALL bus_oe=1 while RD_l=0.
REQ-025 On the last GAP2 cycle, SHALL go to IDLE and assert done=1 for exactly the following cycle.
REQ-026 SHALL hold busy=1 in every non-IDLE state and busy=0 in IDLE.
REQ-027 Latency: for start accepted at edge E0, done SHALL be high in the cycle after edge E0+4*T_PH, with data_out valid in that cycle.
REQ-028 SHALL ignore start while busy=1; no request is queued and the latched address is not changed.
REQ-029 SHALL accept start in the cycle where done=1 (back-to-back reads), giving 4*T_PH+1 cycles per read.
REQ-030 With T_PH=1, SHALL give each phase exactly one cycle, with no dropped or merged phases.
REQ-031 SHALL not change the internal address register after a start is accepted, even if the addr input changes.

Reset
REQ-032 While reset=0, SHALL asynchronously force: state=IDLE, counter=0, AD_l=CS_l=RD_l=RW_l=1, bus_oe=0, bus_out=0x00, data_out=0x00, busy=0, done=0.
REQ-033 Reset during any phase SHALL abort the cycle immediately, with no done pulse and no data_out update.
REQ-034 After reset is released, SHALL wait in IDLE for a new start.

Verification
REQ-035 Basic read, T_PH=4: start with addr=0x0A, data_in=0x26 -> AD_l/CS_l/RW_l low for 4 cycles with bus_out=0x0A; RD_l low for 4 cycles; done high in cycle 17 after acceptance; data_out=0x26.
REQ-036 Busy ignore: a second start with addr=0x0B during READ -> no effect; only one done pulse; data_out comes from the addr 0x0A read.
REQ-037 Back-to-back: start held high continuously over two reads -> the second ADDR phase begins in the cycle done=1; period is 17 cycles; both data values are captured.
REQ-038 Mid-cycle reset: reset=0 on the 2nd READ cycle -> all strobes return to 1 and bus_oe=0 asynchronously; no done pulse; data_out=0x00.
REQ-039 T_PH=1: single read -> each phase lasts one cycle; done is high 5 cycles after acceptance.
REQ-040 Protocol checker over all tests: never RD_l=0 and RW_l=0 together; never bus_oe=1 while RD_l=0; AD_l=0 only while CS_l=0.

Source files
------------

// File: rtl/rtc_bus_reader.sv
// Multiplexed-bus RTC register reader: ADDR -> GAP1 -> READ -> GAP2, each phase T_PH clocks.
// Strobes and bus drive are flopped so they change only on clock edges.
module rtc_bus_reader #(
  parameter int T_PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic       AD_l,
  output logic       CS_l,
  output logic       RD_l,
  output logic       RW_l,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_GAP2 = 3'd4;
  localparam logic [7:0] LAST   = 8'(T_PH - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ad_l_q, ad_l_d;
  logic       cs_l_q, cs_l_d;
  logic       rd_l_q, rd_l_d;
  logic       rw_l_q, rw_l_d;
  logic       oe_q, oe_d;
  logic [7:0] bus_q, bus_d;
  logic       phase_last;

  assign phase_last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ADDR;
        addr_d  = addr;
      end
      S_ADDR: if (phase_last) state_d = S_GAP1;
      S_GAP1: if (phase_last) state_d = S_READ;
      S_READ: if (phase_last) state_d = S_GAP2;
      S_GAP2: if (phase_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cnt_d  = ((state_d != state_q) || (state_q == S_IDLE)) ? 8'd0 : cnt_q + 8'd1;
    data_d = ((state_q == S_READ) && phase_last) ? data_in : data_q;
    done_d = (state_q == S_GAP2) && phase_last;
  end

  // Bus controls are decoded from the next state and registered alongside it.
  always_comb begin
    ad_l_d = 1'b1;
    cs_l_d = 1'b1;
    rd_l_d = 1'b1;
    rw_l_d = 1'b1;
    oe_d   = 1'b0;
    bus_d  = 8'h00;
    case (state_d)
      S_ADDR: begin
        ad_l_d = 1'b0;
        cs_l_d = 1'b0;
        rw_l_d = 1'b0;
        oe_d   = 1'b1;
        bus_d  = addr_d;
      end
      S_GAP1: begin
        oe_d  = 1'b1;
        bus_d = addr_d;
      end
      S_READ: begin
        cs_l_d = 1'b0;
        rd_l_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ad_l_q  <= 1'b1;
      cs_l_q  <= 1'b1;
      rd_l_q  <= 1'b1;
      rw_l_q  <= 1'b1;
      oe_q    <= 1'b0;
      bus_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ad_l_q  <= ad_l_d;
      cs_l_q  <= cs_l_d;
      rd_l_q  <= rd_l_d;
      rw_l_q  <= rw_l_d;
      oe_q    <= oe_d;
      bus_q   <= bus_d;
    end
  end

  assign AD_l     = ad_l_q;
  assign CS_l     = cs_l_q;
  assign RD_l     = rd_l_q;
  assign RW_l     = rw_l_q;
  assign bus_oe   = oe_q;
  assign bus_out  = bus_q;
  assign data_out = data_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader: one instance at T_PH=4, one at T_PH=1, each with a small RTC model.
module tb_rtc_bus_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] addr_a = 8'h00, addr_b = 8'h00;
  logic [7:0] data_in_a, data_in_b;
  logic       ad_l_a, cs_l_a, rd_l_a, rw_l_a, bus_oe_a, busy_a, done_a;
  logic       ad_l_b, cs_l_b, rd_l_b, rw_l_b, bus_oe_b, busy_b, done_b;
  logic [7:0] bus_out_a, data_out_a, bus_out_b, data_out_b;
  logic [7:0] rtc_addr_a = 8'h00, rtc_addr_b = 8'h00;

  wire [4:0] ctrl_a = {ad_l_a, cs_l_a, rd_l_a, rw_l_a, bus_oe_a};
  wire [4:0] ctrl_b = {ad_l_b, cs_l_b, rd_l_b, rw_l_b, bus_oe_b};

  localparam logic [4:0] C_ADDR = 5'b00101;
  localparam logic [4:0] C_GAP1 = 5'b11111;
  localparam logic [4:0] C_READ = 5'b10010;
  localparam logic [4:0] C_IDLE = 5'b11110;

  rtc_bus_reader #(.T_PH(4)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .addr(addr_a), .data_in(data_in_a),
    .AD_l(ad_l_a), .CS_l(cs_l_a), .RD_l(rd_l_a), .RW_l(rw_l_a),
    .bus_out(bus_out_a), .bus_oe(bus_oe_a), .data_out(data_out_a),
    .busy(busy_a), .done(done_a)
  );

  rtc_bus_reader #(.T_PH(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .addr(addr_b), .data_in(data_in_b),
    .AD_l(ad_l_b), .CS_l(cs_l_b), .RD_l(rd_l_b), .RW_l(rw_l_b),
    .bus_out(bus_out_b), .bus_oe(bus_oe_b), .data_out(data_out_b),
    .busy(busy_b), .done(done_b)
  );

  // RTC register contents: 0x0A->0x26, 0x0B->0x3C, otherwise addr^0x5A.
  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    case (a)
      8'h0A:   return 8'h26;
      8'h0B:   return 8'h3C;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ad_l_a && !cs_l_a) rtc_addr_a <= bus_out_a;
    if (!ad_l_b && !cs_l_b) rtc_addr_b <= bus_out_b;
  end
  assign data_in_a = rtc_val(rtc_addr_a);
  assign data_in_b = rtc_val(rtc_addr_b);

  // Expected {AD_l,CS_l,RD_l,RW_l,bus_oe} in cycle c after acceptance (c=1 is first ADDR cycle).
  function automatic logic [4:0] exp_ctrl(input int c, input int tph);
    int ph;
    ph = (c - 1) / tph;
    case (ph)
      0:       return C_ADDR;
      1:       return C_GAP1;
      2:       return C_READ;
      default: return C_IDLE;
    endcase
  endfunction

  // Protocol monitor on both instances.
  always @(negedge clk) begin
    vectors = vectors + 2;
    if ((!rd_l_a && !rw_l_a) || (bus_oe_a && !rd_l_a) || (!ad_l_a && cs_l_a)) begin
      miscompares++;
      $display("FAIL protocol_a t=%0t got ctrl=%b", $time, ctrl_a);
    end
    if ((!rd_l_b && !rw_l_b) || (bus_oe_b && !rd_l_b) || (!ad_l_b && cs_l_b)) begin
      miscompares++;
      $display("FAIL protocol_b t=%0t got ctrl=%b", $time, ctrl_b);
    end
  end

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ctrl_a, bus_out_a, data_out_a, busy_a, done_a} !== {C_IDLE, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_a got ctrl=%b bus=%h dout=%h busy=%b done=%b want ctrl=%b zeros",
               ctrl_a, bus_out_a, data_out_a, busy_a, done_a, C_IDLE);
    end
    vectors++;
    if ({ctrl_b, bus_out_b, data_out_b, busy_b, done_b} !== {C_IDLE, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_b got ctrl=%b bus=%h dout=%h busy=%b done=%b", ctrl_b, bus_out_b,
               data_out_b, busy_b, done_b);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0 || ctrl_a !== C_IDLE) begin
      miscompares++;
      $display("FAIL idle_after_reset got busy=%b ctrl=%b want 0 %b", busy_a, ctrl_a, C_IDLE);
    end
  endtask

  task automatic test_basic_read;
    logic [4:0] exp_c;
    @(negedge clk);
    start_a = 1'b1;
    addr_a  = 8'h0A;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_c = exp_ctrl(c, 4);
      vectors++;
      if (ctrl_a !== exp_c) begin
        miscompares++;
        $display("FAIL basic_ctrl c=%0d got %b want %b", c, ctrl_a, exp_c);
      end
      if (c <= 8) begin
        vectors++;
        if (bus_out_a !== 8'h0A) begin
          miscompares++;
          $display("FAIL basic_bus c=%0d got %h want 0a", c, bus_out_a);
        end
      end
      vectors++;
      if (busy_a !== (c <= 16) || done_a !== (c == 17)) begin
        miscompares++;
        $display("FAIL basic_busy_done c=%0d got busy=%b done=%b want %b %b", c, busy_a, done_a,
                 c <= 16, c == 17);
      end
      vectors++;
      if (data_out_a !== ((c >= 13) ? 8'h26 : 8'h00)) begin
        miscompares++;
        $display("FAIL basic_dout c=%0d got %h want %h", c, data_out_a, (c >= 13) ? 8'h26 : 8'h00);
      end
      if (c == 1) begin
        start_a = 1'b0;
        addr_a  = 8'h77;
      end
    end
  endtask

  task automatic test_busy_ignore;
    int ndone = 0;
    int dcyc = 0;
    @(negedge clk);
    start_a = 1'b1;
    addr_a  = 8'h0A;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        ndone++;
        dcyc = c;
      end
      if (c == 1) start_a = 1'b0;
      if (c == 10) begin
        start_a = 1'b1;
        addr_a  = 8'h0B;
      end
      if (c == 15) start_a = 1'b0;
    end
    vectors++;
    if (ndone != 1 || dcyc != 17) begin
      miscompares++;
      $display("FAIL busy_ignore_done got count=%0d cycle=%0d want 1 17", ndone, dcyc);
    end
    vectors++;
    if (data_out_a !== 8'h26 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore_dout got %h busy=%b want 26 0", data_out_a, busy_a);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int d1 = 0;
    int d2 = 0;
    @(negedge clk);
    start_a = 1'b1;
    addr_a  = 8'h0B;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        ndone++;
        if (ndone == 1) d1 = c;
        else d2 = c;
      end
      if (c == 17) begin
        vectors++;
        if (data_out_a !== 8'h3C || busy_a !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_first got dout=%h busy=%b want 3c 0", data_out_a, busy_a);
        end
      end
      if (c == 18) begin
        vectors++;
        if (ctrl_a !== C_ADDR || bus_out_a !== 8'h11 || busy_a !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart got ctrl=%b bus=%h busy=%b want %b 11 1", ctrl_a, bus_out_a,
                   busy_a, C_ADDR);
        end
        start_a = 1'b0;
      end
      if (c == 34) begin
        vectors++;
        if (data_out_a !== 8'h4B) begin
          miscompares++;
          $display("FAIL b2b_second got dout=%h want 4b", data_out_a);
        end
      end
      if (c == 1) addr_a = 8'h11;
    end
    vectors++;
    if (ndone != 2 || d1 != 17 || d2 != 34) begin
      miscompares++;
      $display("FAIL b2b_period got count=%0d at %0d,%0d want 2 at 17,34", ndone, d1, d2);
    end
  endtask

  task automatic test_mid_reset;
    int ndone = 0;
    @(negedge clk);
    start_a = 1'b1;
    addr_a  = 8'h0A;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
    end
    vectors++;
    if (ctrl_a !== C_READ) begin
      miscompares++;
      $display("FAIL midrst_pre got ctrl=%b want %b", ctrl_a, C_READ);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({ctrl_a, bus_out_a, data_out_a, busy_a, done_a} !== {C_IDLE, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_async got ctrl=%b bus=%h dout=%h busy=%b done=%b", ctrl_a, bus_out_a,
               data_out_a, busy_a, done_a);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) ndone++;
    end
    vectors++;
    if (ndone != 0 || data_out_a !== 8'h00 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_after got done_count=%0d dout=%h busy=%b want 0 00 0", ndone,
               data_out_a, busy_a);
    end
  endtask

  task automatic test_tph1;
    logic [4:0] exp_c;
    @(negedge clk);
    start_b = 1'b1;
    addr_b  = 8'h0B;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_c = exp_ctrl(c, 1);
      vectors++;
      if (ctrl_b !== exp_c) begin
        miscompares++;
        $display("FAIL tph1_ctrl c=%0d got %b want %b", c, ctrl_b, exp_c);
      end
      vectors++;
      if (busy_b !== (c <= 4) || done_b !== (c == 5)) begin
        miscompares++;
        $display("FAIL tph1_busy_done c=%0d got busy=%b done=%b want %b %b", c, busy_b, done_b,
                 c <= 4, c == 5);
      end
      vectors++;
      if (data_out_b !== ((c >= 4) ? 8'h3C : 8'h00)) begin
        miscompares++;
        $display("FAIL tph1_dout c=%0d got %h want %h", c, data_out_b, (c >= 4) ? 8'h3C : 8'h00);
      end
      if (c <= 2) begin
        vectors++;
        if (bus_out_b !== 8'h0B) begin
          miscompares++;
          $display("FAIL tph1_bus c=%0d got %h want 0b", c, bus_out_b);
        end
      end
      if (c == 1) start_b = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_tph1();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
